// File: rtl/custom_axi_regif_pkg.sv
// custom_axi_regif_pkg: shared constants, response codes and FSM state types for the AXI-Lite register interface.
package custom_axi_regif_pkg;
    localparam int NUM_REGS_DEF = 3;
    localparam logic [3:0] REG0_OFFSET = 4'h0;
    localparam logic [3:0] REG1_OFFSET = 4'h4;
    localparam logic [3:0] REG2_OFFSET = 4'h8;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} wr_state_e;
    typedef enum logic {R_IDLE, R_DATA} rd_state_e;
    function automatic logic idx_valid(input int unsigned idx, input int unsigned n);
        return idx < n;
    endfunction
endpackage

// File: rtl/custom_axi_regif_wch.sv
// custom_axi_regif_wch: AW/W latching and write FSM; hands the top a register index, byte-merged word and exec strobe.
module custom_axi_regif_wch
    import custom_axi_regif_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int ADDR_W   = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      up_i,
    input  logic [ADDR_W-1:0]         s_awaddr_i,
    input  logic                      s_awvalid_i,
    output logic                      s_awready_o,
    input  logic [31:0]               s_wdata_i,
    input  logic [3:0]                s_wstrb_i,
    input  logic                      s_wvalid_i,
    output logic                      s_wready_o,
    output logic [1:0]                s_bresp_o,
    output logic                      s_bvalid_o,
    input  logic                      s_bready_i,
    input  logic [NUM_REGS-1:0][31:0] regs_i,
    output logic [ADDR_W-3:0]         wr_idx_o,
    output logic [31:0]               wr_data_o,
    output logic                      wr_exec_o
);
    wr_state_e         state_q;
    logic              aw_held_q, w_held_q, aw_hs, w_hs, ok;
    logic [ADDR_W-3:0] idx_q;
    logic [31:0]       data_q, cur;
    logic [3:0]        strb_q;
    logic              unused_awaddr;

    assign unused_awaddr = ^s_awaddr_i[1:0];
    assign ok          = idx_valid(32'(idx_q), NUM_REGS);
    assign s_awready_o = up_i & ~aw_held_q;
    assign s_wready_o  = up_i & ~w_held_q;
    assign aw_hs       = s_awvalid_i & s_awready_o;
    assign w_hs        = s_wvalid_i & s_wready_o;
    assign cur         = ok ? regs_i[idx_q] : '0;
    assign wr_idx_o    = idx_q;
    assign wr_exec_o   = (state_q == W_EXEC) & ok;

    // Unstrobed bytes keep the register's value as seen in the exec cycle.
    for (genvar b = 0; b < 4; b++) begin : g_merge
        assign wr_data_o[8*b +: 8] = strb_q[b] ? data_q[8*b +: 8] : cur[8*b +: 8];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= W_IDLE;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            idx_q      <= '0;
            data_q     <= '0;
            strb_q     <= '0;
            s_bvalid_o <= 1'b0;
            s_bresp_o  <= RESP_OKAY;
        end else begin
            case (state_q)
                W_IDLE: begin
                    if (aw_hs) begin
                        aw_held_q <= 1'b1;
                        idx_q     <= s_awaddr_i[ADDR_W-1:2];
                    end
                    if (w_hs) begin
                        w_held_q <= 1'b1;
                        data_q   <= s_wdata_i;
                        strb_q   <= s_wstrb_i;
                    end
                    if ((aw_held_q | aw_hs) & (w_held_q | w_hs)) state_q <= W_EXEC;
                end
                W_EXEC: begin
                    state_q    <= W_RESP;
                    s_bvalid_o <= 1'b1;
                    s_bresp_o  <= ok ? RESP_OKAY : RESP_SLVERR;
                end
                W_RESP: if (s_bready_i) begin
                    state_q    <= W_IDLE;
                    s_bvalid_o <= 1'b0;
                    aw_held_q  <= 1'b0;
                    w_held_q   <= 1'b0;
                end
                default: state_q <= W_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/custom_axi_regif.sv
// custom_axi_regif: AXI4-Lite slave register file; bus writes drive reg2ip data/strobes, ip2reg updates fold in.
module custom_axi_regif
    import custom_axi_regif_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int ADDR_W   = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [ADDR_W-1:0]         s_awaddr_i,
    input  logic                      s_awvalid_i,
    output logic                      s_awready_o,
    input  logic [31:0]               s_wdata_i,
    input  logic [3:0]                s_wstrb_i,
    input  logic                      s_wvalid_i,
    output logic                      s_wready_o,
    output logic [1:0]                s_bresp_o,
    output logic                      s_bvalid_o,
    input  logic                      s_bready_i,
    input  logic [ADDR_W-1:0]         s_araddr_i,
    input  logic                      s_arvalid_i,
    output logic                      s_arready_o,
    output logic [31:0]               s_rdata_o,
    output logic [1:0]                s_rresp_o,
    output logic                      s_rvalid_o,
    input  logic                      s_rready_i,
    output logic [NUM_REGS-1:0][31:0] reg2ip_data_o,
    output logic [NUM_REGS-1:0]       reg2ip_en_o,
    input  logic [NUM_REGS-1:0][31:0] ip2reg_data_i,
    input  logic [NUM_REGS-1:0]       ip2reg_en_i
);
    logic [NUM_REGS-1:0][31:0] regs_q;
    logic [NUM_REGS-1:0]       en_q, wr_sel;
    logic [ADDR_W-3:0]         wr_idx, ar_idx;
    logic [31:0]               wr_data;
    logic                      wr_exec, up_q, ar_ok;
    rd_state_e                 rd_state_q;
    logic                      unused_araddr;

    custom_axi_regif_wch #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) u_wch (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .up_i        (up_q),
        .s_awaddr_i  (s_awaddr_i),
        .s_awvalid_i (s_awvalid_i),
        .s_awready_o (s_awready_o),
        .s_wdata_i   (s_wdata_i),
        .s_wstrb_i   (s_wstrb_i),
        .s_wvalid_i  (s_wvalid_i),
        .s_wready_o  (s_wready_o),
        .s_bresp_o   (s_bresp_o),
        .s_bvalid_o  (s_bvalid_o),
        .s_bready_i  (s_bready_i),
        .regs_i      (regs_q),
        .wr_idx_o    (wr_idx),
        .wr_data_o   (wr_data),
        .wr_exec_o   (wr_exec)
    );

    assign unused_araddr = ^s_araddr_i[1:0];
    assign ar_idx        = s_araddr_i[ADDR_W-1:2];
    assign ar_ok         = idx_valid(32'(ar_idx), NUM_REGS);
    assign s_arready_o   = up_q & (rd_state_q == R_IDLE);
    assign wr_sel        = wr_exec ? NUM_REGS'(1) << wr_idx : '0;
    assign reg2ip_data_o = regs_q;
    assign reg2ip_en_o   = en_q;

    // Bus write beats a same-cycle hardware update; the strobe lands with the new value.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            regs_q <= '0;
            en_q   <= '0;
            up_q   <= 1'b0;
        end else begin
            up_q <= 1'b1;
            en_q <= wr_sel;
            for (int i = 0; i < NUM_REGS; i++)
                if (wr_sel[i]) regs_q[i] <= wr_data;
                else if (ip2reg_en_i[i]) regs_q[i] <= ip2reg_data_i[i];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_state_q <= R_IDLE;
            s_rvalid_o <= 1'b0;
            s_rdata_o  <= '0;
            s_rresp_o  <= RESP_OKAY;
        end else begin
            case (rd_state_q)
                R_IDLE: if (s_arvalid_i & s_arready_o) begin
                    rd_state_q <= R_DATA;
                    s_rvalid_o <= 1'b1;
                    s_rdata_o  <= ar_ok ? regs_q[ar_idx] : '0;
                    s_rresp_o  <= ar_ok ? RESP_OKAY : RESP_SLVERR;
                end
                R_DATA: if (s_rready_i) begin
                    rd_state_q <= R_IDLE;
                    s_rvalid_o <= 1'b0;
                end
                default: rd_state_q <= R_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_custom_axi_regif.sv
// tb_custom_axi_regif: directed vector table, hand sequences for corner cases and randomized traffic against a register model.
module tb_custom_axi_regif;
    import custom_axi_regif_pkg::*;

    logic clk = 0, rst_ni = 0;
    always #5 clk = ~clk;

    logic [3:0]       s_awaddr = 0, s_araddr = 0, s_wstrb = 0;
    logic [31:0]      s_wdata = 0, s_rdata;
    logic             s_awvalid = 0, s_wvalid = 0, s_bready = 0, s_arvalid = 0, s_rready = 0;
    logic             s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
    logic [1:0]       s_bresp, s_rresp;
    logic [2:0][31:0] reg2ip_data, ip_data = '0;
    logic [2:0]       reg2ip_en, ip_en = 0;

    custom_axi_regif #(.NUM_REGS(3), .ADDR_W(4)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .s_awaddr_i(s_awaddr), .s_awvalid_i(s_awvalid), .s_awready_o(s_awready),
        .s_wdata_i(s_wdata), .s_wstrb_i(s_wstrb), .s_wvalid_i(s_wvalid), .s_wready_o(s_wready),
        .s_bresp_o(s_bresp), .s_bvalid_o(s_bvalid), .s_bready_i(s_bready),
        .s_araddr_i(s_araddr), .s_arvalid_i(s_arvalid), .s_arready_o(s_arready),
        .s_rdata_o(s_rdata), .s_rresp_o(s_rresp), .s_rvalid_o(s_rvalid), .s_rready_i(s_rready),
        .reg2ip_data_o(reg2ip_data), .reg2ip_en_o(reg2ip_en),
        .ip2reg_data_i(ip_data), .ip2reg_en_i(ip_en)
    );

    int total = 0, bad = 0;
    logic [31:0] m [3];

    typedef struct {
        logic [3:0]  a;
        logic [31:0] d;
        logic [3:0]  s;
        int          awd, wd;
        logic [2:0]  cen;
        logic [31:0] cval;
        logic [2:0]  en;
        logic [1:0]  resp;
        logic [31:0] rd;
    } vec_t;
    vec_t v [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_regs(input string nm);
        for (int i = 0; i < 3; i++) chk(nm, reg2ip_data[i], m[i]);
    endtask

    task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s, input int awd, input int wd,
                            input logic [2:0] cen, input logic [31:0] cval, input int hold,
                            output logic [1:0] resp, output logic [2:0] en);
        bit awdone = 0, wdone = 0, ahs, whs;
        int cyc = 0;
        int idx = int'(a[3:2]);
        resp = '1;
        en = '1;
        while (!(awdone && wdone)) begin
            s_awvalid = !awdone && cyc >= awd;
            s_awaddr  = a;
            s_wvalid  = !wdone && cyc >= wd;
            s_wdata   = d;
            s_wstrb   = s;
            ahs = s_awvalid && s_awready;
            whs = s_wvalid && s_wready;
            tick();
            awdone |= ahs;
            wdone  |= whs;
            cyc++;
            if (cyc > 50) begin
                chk("write_handshake_timeout", 0, 1);
                s_awvalid = 0;
                s_wvalid = 0;
                return;
            end
        end
        s_awvalid = 0;
        s_wvalid = 0;
        chk("exec_bvalid", 32'(s_bvalid), 0);
        chk("exec_en", 32'(reg2ip_en), 0);
        ip_en = cen;
        for (int i = 0; i < 3; i++) ip_data[i] = cval;
        tick();
        ip_en = 0;
        for (int i = 0; i < 3; i++)
            if (idx < 3 && idx == i) m[i] = merge(m[i], d, s);
            else if (cen[i]) m[i] = cval;
        chk("bvalid", 32'(s_bvalid), 1);
        chk_regs("reg2ip_data");
        resp = s_bresp;
        en = reg2ip_en;
        s_bready = (hold == 0);
        for (int k = 0; k < hold; k++) begin
            s_awvalid = 1;
            s_wvalid = 1;
            chk("bp_awready", 32'(s_awready), 0);
            chk("bp_wready", 32'(s_wready), 0);
            tick();
            chk("bp_bvalid", 32'(s_bvalid), 1);
            chk("bp_bresp", 32'(s_bresp), 32'(resp));
            chk("bp_en", 32'(reg2ip_en), 0);
        end
        s_awvalid = 0;
        s_wvalid = 0;
        s_bready = 1;
        tick();
        chk("bvalid_clear", 32'(s_bvalid), 0);
        chk("en_clear", 32'(reg2ip_en), 0);
        s_bready = 0;
    endtask

    task automatic do_read(input logic [3:0] a, input int hold, output logic [31:0] data, output logic [1:0] resp);
        int n = 0;
        data = '1;
        resp = '1;
        s_araddr = a;
        s_arvalid = 1;
        while (!s_arready) begin
            tick();
            if (++n > 50) begin
                chk("ar_timeout", 0, 1);
                s_arvalid = 0;
                return;
            end
        end
        tick();
        s_arvalid = 0;
        chk("rvalid", 32'(s_rvalid), 1);
        data = s_rdata;
        resp = s_rresp;
        s_rready = (hold == 0);
        for (int k = 0; k < hold; k++) begin
            s_arvalid = 1;
            chk("bp_arready", 32'(s_arready), 0);
            tick();
            chk("bp_rvalid", 32'(s_rvalid), 1);
            chk("bp_rdata", s_rdata, data);
            chk("bp_rresp", 32'(s_rresp), 32'(resp));
        end
        s_arvalid = 0;
        s_rready = 1;
        tick();
        chk("rvalid_clear", 32'(s_rvalid), 0);
        s_rready = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [1:0]  resp, rresp;
        logic [2:0]  en, mask;
        logic [31:0] rd;
        logic [3:0]  a;
        int          idx;
        v[0] = '{4'h0, 32'h11223344, 4'hF, 0, 0, 3'b000, 32'h0, 3'b001, RESP_OKAY,   32'h11223344};
        v[1] = '{4'h0, 32'hAABBCCDD, 4'h5, 1, 0, 3'b000, 32'h0, 3'b001, RESP_OKAY,   32'h11BB33DD};
        v[2] = '{REG2_OFFSET, 32'hDEADBEEF, 4'hF, 0, 2, 3'b000, 32'h0, 3'b100, RESP_OKAY, 32'hDEADBEEF};
        v[3] = '{4'h4, 32'h12345678, 4'h0, 0, 0, 3'b000, 32'h0, 3'b010, RESP_OKAY,   32'h00000000};
        v[4] = '{4'hC, 32'hFFFFFFFF, 4'hF, 0, 0, 3'b000, 32'h0, 3'b000, RESP_SLVERR, 32'h00000000};
        v[5] = '{4'h5, 32'hCAFEF00D, 4'hC, 2, 2, 3'b000, 32'h0, 3'b010, RESP_OKAY,   32'hCAFE0000};
        v[6] = '{4'h6, 32'h0000BEEF, 4'h3, 3, 0, 3'b000, 32'h0, 3'b010, RESP_OKAY,   32'hCAFEBEEF};
        v[7] = '{REG1_OFFSET, 32'h7, 4'hF, 0, 1, 3'b011, 32'h5, 3'b010, RESP_OKAY, 32'h00000007};
        for (int i = 0; i < 3; i++) m[i] = 0;

        repeat (3) tick();
        chk("rst_awready", 32'(s_awready), 0);
        chk("rst_wready", 32'(s_wready), 0);
        chk("rst_arready", 32'(s_arready), 0);
        chk("rst_bvalid", 32'(s_bvalid), 0);
        chk("rst_rvalid", 32'(s_rvalid), 0);
        chk("rst_bresp", 32'(s_bresp), 0);
        chk("rst_rresp", 32'(s_rresp), 0);
        chk("rst_rdata", s_rdata, 0);
        chk("rst_en", 32'(reg2ip_en), 0);
        chk_regs("rst_regs");
        rst_ni = 1;
        tick();
        chk("up_awready", 32'(s_awready), 1);
        chk("up_wready", 32'(s_wready), 1);
        chk("up_arready", 32'(s_arready), 1);
        do_read(REG1_OFFSET, 0, rd, rresp);
        chk("rst_read_data", rd, 0);
        chk("rst_read_resp", 32'(rresp), 32'(RESP_OKAY));

        for (int i = 0; i < 8; i++) begin
            do_write(v[i].a, v[i].d, v[i].s, v[i].awd, v[i].wd, v[i].cen, v[i].cval, 0, resp, en);
            chk($sformatf("vec%0d_bresp", i), 32'(resp), 32'(v[i].resp));
            chk($sformatf("vec%0d_en", i), 32'(en), 32'(v[i].en));
            do_read(v[i].a, 0, rd, rresp);
            chk($sformatf("vec%0d_rdata", i), rd, v[i].rd);
            chk($sformatf("vec%0d_rresp", i), 32'(rresp), 32'(v[i].resp));
        end
        chk("coll_reg0_hw", reg2ip_data[0], 32'h5);

        s_araddr = REG2_OFFSET;
        s_arvalid = 1;
        ip_en = 3'b100;
        ip_data[2] = 32'h0BADF00D;
        chk("rdupd_arready", 32'(s_arready), 1);
        tick();
        s_arvalid = 0;
        ip_en = 0;
        chk("rdupd_pre_value", s_rdata, m[2]);
        m[2] = 32'h0BADF00D;
        chk_regs("rdupd_regs");
        s_rready = 1;
        tick();
        s_rready = 0;
        chk("rdupd_rvalid_clear", 32'(s_rvalid), 0);

        do_write(REG2_OFFSET, 32'h0F0F0F0F, 4'hF, 0, 0, 3'b000, 0, 5, resp, en);
        chk("bp_write_resp", 32'(resp), 32'(RESP_OKAY));
        chk("bp_write_en", 32'(en), 32'b100);
        do_read(REG2_OFFSET, 5, rd, rresp);
        chk("bp_read_data", rd, 32'h0F0F0F0F);
        do_read(4'hC, 5, rd, rresp);
        chk("bp_bad_read_resp", 32'(rresp), 32'(RESP_SLVERR));
        chk("bp_bad_read_data", rd, 0);

        s_awaddr = 4'h0;
        s_wdata = 32'hFFFFFFFF;
        s_wstrb = 4'hF;
        s_awvalid = 1;
        s_wvalid = 1;
        tick();
        s_awvalid = 0;
        s_wvalid = 0;
        rst_ni = 0;
        #1;
        for (int i = 0; i < 3; i++) m[i] = 0;
        chk("midrst_bvalid", 32'(s_bvalid), 0);
        chk("midrst_en", 32'(reg2ip_en), 0);
        chk("midrst_awready", 32'(s_awready), 0);
        chk_regs("midrst_regs");
        tick();
        chk("midrst_en_after", 32'(reg2ip_en), 0);
        chk("midrst_bvalid_after", 32'(s_bvalid), 0);
        rst_ni = 1;
        tick();
        tick();
        chk("midrst_regs_after", reg2ip_data[0], 0);
        chk("midrst_awready_up", 32'(s_awready), 1);
        chk("midrst_arready_up", 32'(s_arready), 1);

        for (int it = 0; it < 80; it++) begin
            case ($urandom_range(0, 2))
                0: begin
                    a = 4'($urandom_range(0, 15));
                    idx = int'(a[3:2]);
                    mask = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
                    do_write(a, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                             mask, $urandom, 0, resp, en);
                    chk("rnd_bresp", 32'(resp), (idx < 3) ? 32'(RESP_OKAY) : 32'(RESP_SLVERR));
                    chk("rnd_en", 32'(en), (idx < 3) ? (32'd1 << idx) : 32'd0);
                end
                1: begin
                    a = 4'($urandom_range(0, 15));
                    idx = int'(a[3:2]);
                    do_read(a, 0, rd, rresp);
                    chk("rnd_rdata", rd, (idx < 3) ? m[idx] : 32'h0);
                    chk("rnd_rresp", 32'(rresp), (idx < 3) ? 32'(RESP_OKAY) : 32'(RESP_SLVERR));
                end
                default: begin
                    mask = 3'($urandom);
                    for (int i = 0; i < 3; i++) ip_data[i] = $urandom;
                    ip_en = mask;
                    tick();
                    ip_en = 0;
                    for (int i = 0; i < 3; i++) if (mask[i]) m[i] = ip_data[i];
                    chk_regs("rnd_hw_regs");
                    chk("rnd_hw_no_en", 32'(reg2ip_en), 0);
                end
            endcase
        end
        chk_regs("final_regs");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/custom_axi_regif.md
# custom_axi_regif

AXI4-Lite slave register interface that drives the hardware side of the custom AXI IP. It decodes bus writes into per-register data plus one-cycle enable strobes (reg2ip), and absorbs hardware status updates (ip2reg) into the same register array. Bus reads return the current register contents. It sits between the SoC AXI-Lite peripheral interconnect and the custom AXI IP core.

## Interface
- NUM_REGS, 3: number of 32-bit registers; offsets 0x0, 0x4, 0x8, ….
- ADDR_W, 4: AXI-Lite address width; must satisfy 2^ADDR_W ≥ 4·NUM_REGS.
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- s_awaddr_i  in  ADDR_W  write address.
- s_awvalid_i / s_awready_o  in/out  1  AW handshake.
- s_wdata_i  in  32  write data.
- s_wstrb_i  in  4  byte strobes.
- s_wvalid_i / s_wready_o  in/out  1  W handshake.
- s_bresp_o  out  2  write response.
- s_bvalid_o / s_bready_i  out/in  1  B handshake.
- s_araddr_i  in  ADDR_W  read address.
- s_arvalid_i / s_arready_o  in/out  1  AR handshake.
- s_rdata_o  out  32  read data.
- s_rresp_o  out  2  read response.
- s_rvalid_o / s_rready_i  out/in  1  R handshake.
- reg2ip_data_o  out  NUM_REGS×32  current register contents, registered.
- reg2ip_en_o  out  NUM_REGS  one-cycle pulse per register on a bus write.
- ip2reg_data_i  in  NUM_REGS×32  hardware update value.
- ip2reg_en_i  in  NUM_REGS  hardware update enable, sampled every cycle.

## Operation
- Register index is addr[ADDR_W-1:2]; addr[1:0] is ignored. An index ≥ NUM_REGS returns SLVERR (2'b10). Otherwise the response is OKAY (2'b00).
- Write FSM states:
  - W_IDLE: AW and W are accepted independently. Each is latched on its handshake. awready is high while no address is held; wready is high while no data is held. When both are held, go to W_EXEC.
  - W_EXEC (1 cycle): for a valid index, apply the byte-merged write per wstrb. Go to W_RESP.
  - W_RESP: bvalid=1 and bresp is held until bready. Then go to W_IDLE and clear both latches.
- reg2ip_en_o[i] pulses for exactly one cycle, the cycle in which the updated value first appears on reg2ip_data_o[i]. The pulse coincides with the first W_RESP cycle.
- The pulse fires even when wstrb is 0. It does not fire for SLVERR writes.
- Read FSM states:
  - R_IDLE: arready=1. On handshake, capture the register word (or 0 with SLVERR for a bad index) and go to R_DATA.
  - R_DATA: rvalid=1, with rdata/rresp held stable until rready. Then go to R_IDLE.
- Hardware update: ip2reg_en_i[i]=1 loads the full ip2reg_data_i[i] word at the clock edge. It never generates a reg2ip_en pulse.
- Collisions:
  - A W_EXEC bus write and ip2reg_en to the same register in the same cycle: the bus write wins and the hardware value is dropped.
  - Different registers: both updates apply.
  - A read captured in the same cycle as an update returns the pre-update value.
- Read and write channels operate concurrently and independently.

## Timing
- Reset values: all registers 0; reg2ip_data_o=0, reg2ip_en_o=0; bvalid=rvalid=0; bresp=rresp=0; rdata=0.
- awready, wready and arready are 0 during reset and go to 1 in the first cycle after release.
- Write latency: the later of the AW/W handshakes at edge T gives W_EXEC in cycle T+1, and bvalid plus the reg2ip_en pulse in cycle T+2.
- Write throughput: at most one write per 3 cycles when bready is held high.
- Read latency: an AR handshake at edge T gives rvalid in cycle T+1. Throughput is 1 read per 2 cycles with rready held high.
- Outputs never change while valid is held and ready is low.
- Reset asserted mid-transaction: the outstanding AW, W, B, AR and R are dropped. Registers return to 0 and no strobe is emitted.

## Structure
- Package custom_axi_regif_pkg holds:
  - the NUM_REGS default and the register offset constants;
  - RESP_OKAY and RESP_SLVERR;
  - the wr_state_e enum (W_IDLE, W_EXEC, W_RESP) and the rd_state_e enum (R_IDLE, R_DATA).
- One sub-module is natural: custom_axi_regif_wch, containing the AW/W latching and the write FSM. It outputs the write index, merged data and an exec strobe to the top-level register array.
- The read path and the register array stay in the top level.

## Test plan
- Reset: check all outputs are 0, then ready signals rise one cycle after release. Read 0x4 → rdata=0, OKAY.
- AW in cycle 1 and W (0xDEADBEEF, strb 0xF) to 0x8 in cycle 3 → reg2ip_en_o=3'b100 for exactly one cycle, coinciding with bvalid. reg2ip_data_o[2]=0xDEADBEEF. A subsequent read of 0x8 returns 0xDEADBEEF.
- Byte strobe: reg0=0x11223344, then write 0xAABBCCDD with strb 4'b0101 → reg0=0x11BB33DD.
- Collision: ip2reg_en_i[1]=1 with data 0x5 in the W_EXEC cycle of a bus write of 0x7 to 0x4 → reg1=0x7. The same ip2reg update on reg0 in that cycle → reg0=0x5 with no reg2ip_en_o[0] pulse.
- Out of range: write and read to 0xC → SLVERR on both, no reg2ip_en pulse, rdata=0, registers unchanged.
- Backpressure: hold bready=0 and rready=0 for 5 cycles → bvalid, rvalid, rdata and bresp remain stable and no new AW, W or AR is accepted.
